// File: rtl/colon_blink_display.sv
// colon_blink_display: draws a blinking two-dot colon inside a box on the VGA raster
// Ports: clk pixel clock; rst async active-high reset; pixel_x/pixel_y raster position;
//   frame_tick one pulse per frame; sec_tick game-clock second pulse; en draw enable;
//   blink blink mode select; pixel_on registered lit-pixel flag; blink_phase 1=visible half.
// Optional feature: define COLON_SEC_RESYNC_EN to restart the blink phase on sec_tick.
module colon_blink_display #(
   parameter logic [10:0] X_BOX        = 11'd700,
   parameter logic [9:0]  Y_BOX        = 10'd72,
   parameter int          BOX_W        = 20,
   parameter int          BOX_H        = 40,
   parameter int          DOT          = 8,
   parameter int          DOT_Y0       = 8,
   parameter int          DOT_Y1       = 24,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        frame_tick,
   input  logic        sec_tick,
   input  logic        en,
   input  logic        blink,
   output logic        pixel_on,
   output logic        blink_phase
);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [FW-1:0] LAST = FW'(BLINK_FRAMES - 1);
   localparam int XO = (BOX_W - DOT) / 2;
   localparam logic [11:0] BX0 = 12'(X_BOX);
   localparam logic [11:0] BX1 = 12'(X_BOX + BOX_W);
   localparam logic [11:0] BY0 = 12'(Y_BOX);
   localparam logic [11:0] BY1 = 12'(Y_BOX + BOX_H);
   localparam logic [11:0] DX0 = 12'(X_BOX + XO);
   localparam logic [11:0] DX1 = 12'(X_BOX + XO + DOT);
   localparam logic [11:0] U0  = 12'(Y_BOX + DOT_Y0);
   localparam logic [11:0] U1  = 12'(Y_BOX + DOT_Y0 + DOT);
   localparam logic [11:0] L0  = 12'(Y_BOX + DOT_Y1);
   localparam logic [11:0] L1  = 12'(Y_BOX + DOT_Y1 + DOT);

   typedef enum logic {HIDDEN = 1'b0, VISIBLE = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          pixel_on_q, pixel_on_d;
   logic [11:0]   xe, ye;
   logic          in_box, in_dx, in_up, in_lo, hit, resync;

`ifdef COLON_SEC_RESYNC_EN
   assign resync = sec_tick;
`else
   logic unused_sec;
   assign unused_sec = sec_tick;
   assign resync = 1'b0;
`endif

   always_comb begin
      xe = {1'b0, pixel_x};
      ye = {2'b0, pixel_y};
      in_box = xe >= BX0 && xe < BX1 && ye >= BY0 && ye < BY1;
      in_dx = xe >= DX0 && xe < DX1;
      in_up = in_dx && ye >= U0 && ye < U1;
      in_lo = in_dx && ye >= L0 && ye < L1;
      hit = in_box && (in_up || in_lo);
      state_d = state_q;
      fcnt_d = fcnt_q;
      // Leaving blink mode (or a resync) restarts a full visible half-period.
      if (!blink || resync) begin
         state_d = VISIBLE;
         fcnt_d = '0;
      end else if (frame_tick) begin
         fcnt_d = (fcnt_q == LAST) ? '0 : fcnt_q + 1'b1;
         state_d = (fcnt_q != LAST) ? state_q : (state_q == VISIBLE) ? HIDDEN : VISIBLE;
      end
      pixel_on_d = hit && en && (state_q == VISIBLE || !blink);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= VISIBLE;
         fcnt_q <= '0;
         pixel_on_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q <= fcnt_d;
         pixel_on_q <= pixel_on_d;
      end
   end

   assign pixel_on = pixel_on_q;
   assign blink_phase = (state_q == VISIBLE);
endmodule
